// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel among NREQ engines.
// AR requests are granted one at a time; R beats are routed back by ID.
module axi_rd_arbiter #(
    parameter int NREQ    = 3,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ*64-1:0]   rq_araddr,
    input  logic [NREQ*8-1:0]    rq_arlen,
    input  logic [NREQ-1:0]      rq_arvalid,
    output logic [NREQ-1:0]      rq_arready,
    output logic [511:0]         rq_rdata,
    output logic [1:0]           rq_rresp,
    output logic                 rq_rlast,
    output logic [NREQ-1:0]      rq_rvalid,
    input  logic [NREQ-1:0]      rq_rready,
    output logic [15:0]          arid_m,
    output logic [63:0]          araddr_m,
    output logic [7:0]           arlen_m,
    output logic [2:0]           arsize_m,
    output logic                 arvalid_m,
    input  logic                 arready_m,
    input  logic [15:0]          rid_m,
    input  logic [511:0]         rdata_m,
    input  logic [1:0]           rresp_m,
    input  logic                 rlast_m,
    input  logic                 rvalid_m,
    output logic                 rready_m,
    output logic                 idle,
    output logic                 err_bad_id
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      rr_ptr;
    logic [3:0]      out_cnt [NREQ];
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] cnt_zero;
    logic [NREQ-1:0] inc;
    logic [NREQ-1:0] dec;
    logic            found;
    logic [2:0]      winner;
    logic            grant;
    logic [15:0]     ar_id;
    logic [63:0]     ar_addr;
    logic [7:0]      ar_len;
    logic            id_ok;
    logic [2:0]      sel;
    logic            sel_rready;
    logic            sel_zero;
    logic            r_hs;
    logic            dec_hit;
    logic            err_set;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i]     = rq_arvalid[i]
                        && (out_cnt[i] < 4'(MAX_OUT));
            cnt_zero[i] = (out_cnt[i] == 4'd0);
        end
    end

    // First eligible index at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (found)     state_nxt = ISSUE;
            ISSUE: if (arready_m) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant      = (state == IDLE) && found;
        arvalid_m  = (state == ISSUE);
        rq_arready = grant ? (NREQ'(1) << winner) : '0;
        idle       = (state == IDLE) && (&cnt_zero);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            ar_id   <= '0;
            ar_addr <= '0;
            ar_len  <= '0;
        end else if (grant) begin
            rr_ptr  <= (winner == 3'(NREQ - 1))
                     ? 3'd0 : winner + 3'd1;
            ar_id   <= {13'd0, winner};
            ar_addr <= rq_araddr[{winner, 6'd0} +: 64];
            ar_len  <= rq_arlen[{winner, 3'd0} +: 8];
        end
    end

    assign arid_m   = ar_id;
    assign araddr_m = ar_addr;
    assign arlen_m  = ar_len;
    assign arsize_m = 3'd6;

    assign rq_rdata = rdata_m;
    assign rq_rresp = rresp_m;
    assign rq_rlast = rlast_m;

    assign id_ok = (rid_m < 16'(NREQ));
    assign sel   = rid_m[2:0];

    // Loop selection keeps out-of-range IDs from indexing past NREQ.
    always_comb begin
        rq_rvalid  = '0;
        sel_rready = 1'b0;
        sel_zero   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (id_ok && (sel == 3'(i))) begin
                rq_rvalid[i] = rvalid_m;
                sel_rready   = rq_rready[i];
                sel_zero     = cnt_zero[i];
            end
        end
    end

    assign rready_m = id_ok ? sel_rready : 1'b1;
    assign r_hs     = rvalid_m && rready_m;
    assign dec_hit  = r_hs && rlast_m && id_ok && !sel_zero;
    assign err_set  = r_hs
                    && (!id_ok || (rlast_m && sel_zero));

    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NREQ; i++) begin
            inc[i] = grant && (winner == 3'(i));
            dec[i] = dec_hit && (sel == 3'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++)
                out_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (inc[i] && !dec[i])
                    out_cnt[i] <= out_cnt[i] + 4'd1;
                else if (dec[i] && !inc[i])
                    out_cnt[i] <= out_cnt[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err_bad_id <= 1'b0;
        else if (err_set) err_bad_id <= 1'b1;
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: transaction-level model drives requesters
// and memory; a monitor pops expected AR/R transfers from queues.
module tb_axi_rd_arbiter;

    localparam int N    = 3;
    localparam int MAXO = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N*64-1:0]  rq_araddr = '0;
    logic [N*8-1:0]   rq_arlen = '0;
    logic [N-1:0]     rq_arvalid = '0;
    logic [N-1:0]     rq_arready;
    logic [511:0]     rq_rdata;
    logic [1:0]       rq_rresp;
    logic             rq_rlast;
    logic [N-1:0]     rq_rvalid;
    logic [N-1:0]     rq_rready = '0;
    logic [15:0]      arid_m;
    logic [63:0]      araddr_m;
    logic [7:0]       arlen_m;
    logic [2:0]       arsize_m;
    logic             arvalid_m;
    logic             arready_m = 1'b0;
    logic [15:0]      rid_m = '0;
    logic [511:0]     rdata_m = '0;
    logic [1:0]       rresp_m = '0;
    logic             rlast_m = 1'b0;
    logic             rvalid_m = 1'b0;
    logic             rready_m;
    logic             idle;
    logic             err_bad_id;

    axi_rd_arbiter #(.NREQ(N), .MAX_OUT(MAXO)) dut (
        .clk(clk), .rst(rst),
        .rq_araddr(rq_araddr), .rq_arlen(rq_arlen),
        .rq_arvalid(rq_arvalid), .rq_arready(rq_arready),
        .rq_rdata(rq_rdata), .rq_rresp(rq_rresp),
        .rq_rlast(rq_rlast), .rq_rvalid(rq_rvalid),
        .rq_rready(rq_rready),
        .arid_m(arid_m), .araddr_m(araddr_m),
        .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m),
        .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m),
        .idle(idle), .err_bad_id(err_bad_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        int           id;
        logic [511:0] data;
        logic [1:0]   resp;
        logic         last;
    } rb_t;

    int checks = 0;
    int errors = 0;

    logic [63:0] pend_a [N][$];
    logic [7:0]  pend_l [N][$];
    int          mem_q  [N][$];
    ar_t         exp_ar [$];
    rb_t         exp_r  [$];
    int          glog_id  [$];
    int          glog_cyc [$];

    int  m_cnt [N];
    int  m_ptr = 0;
    bit  m_busy = 0;
    ar_t m_cur;
    bit  m_err = 0;
    int  cyc = 0;

    bit run = 0;
    bit r_en = 0;
    int ar_pct = 100;
    int rr_pct = 100;
    int bad_pct = 0;
    int gen_pct = 0;

    bit           r_act = 0;
    bit           r_bad = 0;
    int           r_id = 0;
    logic [511:0] r_data = '0;
    logic [1:0]   r_resp = '0;
    bit           r_last = 0;

    task automatic chk(string name, logic [511:0] act,
                       logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit quiet();
        bit q;
        q = !m_busy && !r_act;
        for (int i = 0; i < N; i++)
            if (pend_a[i].size() != 0 || mem_q[i].size() != 0
                || m_cnt[i] != 0) q = 0;
        return q;
    endfunction

    // Reference behaviour evaluated once per cycle at mid-cycle.
    task automatic model_step();
        int c0 [N];
        int w;
        int idx;
        logic [N-1:0] eg;
        bit allz;
        bit hs;
        cyc++;
        c0 = m_cnt;
        allz = 1;
        for (int i = 0; i < N; i++) if (c0[i] != 0) allz = 0;
        chk("idle", idle, !m_busy && allz);
        chk("err_bad_id", err_bad_id, m_err);
        chk("arvalid_m", arvalid_m, m_busy);
        w = -1;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && rq_arvalid[idx] && c0[idx] < MAXO)
                    w = idx;
            end
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("rq_arready", rq_arready, eg);
        for (int i = 0; i < N; i++) begin
            if (rq_arready[i]) begin
                glog_id.push_back(i);
                glog_cyc.push_back(cyc);
            end
        end
        if (w >= 0) begin
            m_cur.id   = w;
            m_cur.addr = pend_a[w].pop_front();
            m_cur.len  = pend_l[w].pop_front();
            exp_ar.push_back(m_cur);
            m_cnt[w]++;
            m_ptr  = (w + 1) % N;
            m_busy = 1;
        end else if (m_busy && arready_m) begin
            m_busy = 0;
            mem_q[m_cur.id].push_back(int'(m_cur.len) + 1);
        end
        if (r_act) begin
            eg = '0;
            if (!r_bad) eg[r_id] = 1'b1;
            hs = r_bad ? 1'b1 : rq_rready[r_id];
            chk("rq_rvalid", rq_rvalid, eg);
            chk("rready_m", rready_m, hs);
            if (hs) begin
                if (r_bad) m_err = 1;
                else begin
                    mem_q[r_id][0]--;
                    if (mem_q[r_id][0] == 0)
                        void'(mem_q[r_id].pop_front());
                    if (r_last) begin
                        if (c0[r_id] == 0) m_err = 1;
                        else m_cnt[r_id]--;
                    end
                end
                r_act = 0;
            end
        end else begin
            chk("rq_rvalid_none", rq_rvalid, '0);
        end
    endtask

    task automatic drive();
        int ids [$];
        for (int i = 0; i < N; i++) begin
            if (gen_pct > 0 && pend_a[i].size() < 3
                && $urandom_range(99) < gen_pct) begin
                pend_a[i].push_back({$urandom, $urandom} & ~64'h3f);
                pend_l[i].push_back(8'($urandom_range(7)));
            end
            rq_arvalid[i] = pend_a[i].size() > 0;
            if (rq_arvalid[i]) begin
                rq_araddr[64*i +: 64] = pend_a[i][0];
                rq_arlen[8*i +: 8]    = pend_l[i][0];
            end
            rq_rready[i] = $urandom_range(99) < rr_pct;
        end
        arready_m = $urandom_range(99) < ar_pct;
        if (!r_act && r_en) begin
            if (bad_pct > 0 && $urandom_range(99) < bad_pct) begin
                r_act  = 1;
                r_bad  = 1;
                rid_m  = 16'($urandom_range(7, N));
                r_data = rnd512();
                r_resp = 2'($urandom_range(3));
                r_last = 1'($urandom_range(1));
            end else begin
                for (int i = 0; i < N; i++)
                    if (mem_q[i].size() > 0) ids.push_back(i);
                if (ids.size() > 0) begin
                    r_id   = ids[$urandom_range(ids.size() - 1)];
                    r_act  = 1;
                    r_bad  = 0;
                    rid_m  = 16'(r_id);
                    r_data = rnd512();
                    r_resp = 2'($urandom_range(3));
                    r_last = (mem_q[r_id][0] == 1);
                    exp_r.push_back('{r_id, r_data, r_resp, r_last});
                end
            end
        end
        rvalid_m = r_act;
        rdata_m  = r_data;
        rresp_m  = r_resp;
        rlast_m  = r_last;
    endtask

    initial forever begin
        @(negedge clk);
        if (run) model_step();
        @(posedge clk);
        #1;
        if (run) drive();
    end

    ar_t mon_ar;
    rb_t mon_r;

    initial forever begin
        @(negedge clk);
        if (arvalid_m && arready_m) begin
            if (exp_ar.size() == 0) begin
                chk("ar_unexpected", 1'b1, 1'b0);
            end else begin
                mon_ar = exp_ar.pop_front();
                chk("arid_m", arid_m, 16'(mon_ar.id));
                chk("araddr_m", araddr_m, mon_ar.addr);
                chk("arlen_m", arlen_m, mon_ar.len);
                chk("arsize_m", arsize_m, 3'd6);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rq_rvalid[i] && rq_rready[i]) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected", 1'b1, 1'b0);
                end else begin
                    mon_r = exp_r.pop_front();
                    chk("r_owner", i, mon_r.id);
                    chk("rq_rdata", rq_rdata, mon_r.data);
                    chk("rq_rresp", rq_rresp, mon_r.resp);
                    chk("rq_rlast", rq_rlast, mon_r.last);
                end
            end
        end
    end

    task automatic wait_drain(int n);
        bit done;
        done = 0;
        for (int k = 0; k < n && !done; k++) begin
            @(negedge clk);
            done = quiet();
        end
        if (!done) chk("drain_timeout", 1'b1, 1'b0);
        @(negedge clk);
    endtask

    function automatic int count_id(int id);
        int c;
        c = 0;
        foreach (glog_id[k]) if (glog_id[k] == id) c++;
        return c;
    endfunction

    initial begin
        #2;
        chk("rst_arvalid", arvalid_m, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_arready", rq_arready, '0);
        chk("rst_err", err_bad_id, 1'b0);
        chk("rst_arid", arid_m, '0);
        chk("rst_araddr", araddr_m, '0);
        chk("rst_arlen", arlen_m, '0);
        chk("rst_arsize", arsize_m, 3'd6);
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        rst = 0;
        run = 1;

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 2; j++) begin
                pend_a[i].push_back(64'h1000 * (i + 1) + 64 * j);
                pend_l[i].push_back(8'(i + j));
            end
        end
        repeat (16) @(negedge clk);
        chk("fair_cnt", glog_id.size(), 6);
        for (int k = 0; k < 6 && k < glog_id.size(); k++)
            chk("fair_order", glog_id[k], k % N);
        for (int k = 1; k < 6 && k < glog_cyc.size(); k++)
            chk("fair_gap", glog_cyc[k] - glog_cyc[k-1], 2);

        r_en = 1;
        wait_drain(400);
        chk("drain_idle", idle, 1'b1);

        r_en = 0;
        glog_id.delete();
        glog_cyc.delete();
        for (int j = 0; j < 5; j++) begin
            pend_a[0].push_back(64'h8000 + 64 * j);
            pend_l[0].push_back(8'd1);
        end
        repeat (14) @(negedge clk);
        chk("lim_grants", count_id(0), MAXO);
        chk("lim_busy", idle, 1'b0);
        pend_a[2].push_back(64'h9000);
        pend_l[2].push_back(8'd0);
        repeat (4) @(negedge clk);
        chk("lim_other", count_id(2), 1);
        r_en = 1;
        wait_drain(400);
        chk("lim_after", count_id(0), 5);

        gen_pct = 15;
        ar_pct  = 60;
        rr_pct  = 60;
        bad_pct = 3;
        repeat (3000) @(negedge clk);
        gen_pct = 0;
        bad_pct = 0;
        ar_pct  = 100;
        rr_pct  = 100;
        wait_drain(2000);
        chk("ar_left", exp_ar.size(), 0);
        chk("r_left", exp_r.size(), 0);
        chk("err_sticky", err_bad_id, 1'b1);

        ar_pct = 0;
        pend_a[1].push_back(64'hA000);
        pend_l[1].push_back(8'd3);
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                seen = arvalid_m;
            end
            if (!seen) chk("issue_timeout", 1'b1, 1'b0);
        end
        run = 0;
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("mid_rst_arvalid", arvalid_m, 1'b0);
        chk("mid_rst_idle", idle, 1'b1);
        chk("mid_rst_err", err_bad_id, 1'b0);
        chk("mid_rst_arid", arid_m, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        chk("watchdog", 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
